// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmit controller:
// default register addresses, control bit positions and FSM encoding.
package mmio_uart_pkg;

  localparam logic [31:0] DATA_ADDR_DEFAULT = 32'h0000_0100;
  localparam logic [31:0] CTRL_ADDR_DEFAULT = 32'h0000_0101;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;
  localparam int CTRL_CLR_CNT = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

endpackage

// File: rtl/mmio_uart_ctrl_sync_fifo.sv
// Small synchronous FIFO with flush; head data is read combinationally.
// Occupancy is tracked in a level counter that also drives full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign do_push = push && !flush && (!full || do_pop);

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO UART transmit controller: store-bus decode, TX FIFO and byte sequencer.
// Define MMIO_UART_STATS_EN to add the tx_count handshake counter.
module mmio_uart_ctrl
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] DATA_ADDR = DATA_ADDR_DEFAULT,
  parameter logic [31:0] CTRL_ADDR = CTRL_ADDR_DEFAULT,
  parameter int          FIFO_AW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_data,
  input  logic               mem_we,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               tx_en
`ifdef MMIO_UART_STATS_EN
  ,
  output logic [15:0]        tx_count
`endif
);

  logic       data_wr, ctrl_wr, flush, can_pop, pop, drop;
  logic [7:0] fifo_rdata;
  logic       fifo_full, fifo_empty;
  logic [0:0] state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_en_q, tx_en_d;
  logic       overflow_q, overflow_d;
  logic       unused_data_hi;

  assign unused_data_hi = ^mem_data[31:8];

  assign data_wr = mem_we && (mem_addr == DATA_ADDR);
  assign ctrl_wr = mem_we && (mem_addr == CTRL_ADDR);
  assign flush   = ctrl_wr && mem_data[CTRL_FLUSH];
  // A flush in the same cycle wins over fetching a new byte from the FIFO.
  assign can_pop = tx_en_q && !fifo_empty && !flush;
  assign drop    = data_wr && !flush && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (data_wr),
    .pop   (pop),
    .flush (flush),
    .wdata (mem_data[7:0]),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          tx_data_d = fifo_rdata;
          state_d   = SEND;
        end
      end
      default: begin
        if (tx_ready) begin
          if (can_pop) begin
            pop       = 1'b1;
            tx_data_d = fifo_rdata;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    tx_en_d    = ctrl_wr ? mem_data[CTRL_EN] : tx_en_q;
    overflow_d = overflow_q;
    if (ctrl_wr && mem_data[CTRL_CLR_OVF]) overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == SEND);
  assign tx_en    = tx_en_q;
  assign overflow = overflow_q;

`ifdef MMIO_UART_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;

  always_comb begin
    tx_count_d = tx_count_q;
    if (ctrl_wr && mem_data[CTRL_CLR_CNT]) tx_count_d = '0;
    else if (tx_valid && tx_ready)         tx_count_d = tx_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) tx_count_q <= '0;
    else     tx_count_q <= tx_count_d;
  end

  assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Randomised bench for mmio_uart_ctrl against a queue-based transaction model.
// Build with MMIO_UART_STATS_EN defined to also check tx_count.
module tb_mmio_uart_ctrl;

  localparam logic [31:0] DA = 32'h0000_0100;
  localparam logic [31:0] CA = 32'h0000_0101;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_data;
  logic        mem_we;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [3:0]  fifo_level;
  logic        overflow, tx_en;
`ifdef MMIO_UART_STATS_EN
  logic [15:0] tx_count;
`endif

  always #5 clk = ~clk;

  mmio_uart_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .tx_en      (tx_en)
`ifdef MMIO_UART_STATS_EN
    ,
    .tx_count   (tx_count)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: queued bytes, byte on the wire, and status bits.
  logic [7:0]  mq[$];
  logic        m_busy;
  logic [7:0]  m_data;
  logic        m_ovf, m_en;
  logic [15:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_data = 8'h00;
    m_ovf  = 1'b0;
    m_en   = 1'b1;
    m_cnt  = 16'h0;
  endtask

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit is_data  = we && (a == DA);
    bit is_ctrl  = we && (a == CA);
    bit flush    = is_ctrl && d[2];
    bit was_full = (mq.size() == DEPTH);
    bit took     = 1'b0;
    bit dropped  = 1'b0;
    bit hs       = m_busy && rdy;
    if (hs) m_cnt = m_cnt + 16'd1;
    if (m_en && mq.size() > 0 && !flush && (!m_busy || rdy)) begin
      m_data = mq.pop_front();
      m_busy = 1'b1;
      took   = 1'b1;
    end else if (hs) begin
      m_busy = 1'b0;
    end
    if (flush) mq.delete();
    else if (is_data) begin
      if (!was_full || took) mq.push_back(d[7:0]);
      else dropped = 1'b1;
    end
    if (is_ctrl && d[1]) m_ovf = 1'b0;
    if (dropped) m_ovf = 1'b1;
    if (is_ctrl) m_en = d[0];
    if (is_ctrl && d[3]) m_cnt = 16'h0;
  endtask

  task automatic compare_outputs();
    check_eq("tx_valid", tx_valid, m_busy);
    if (m_busy) check_eq("tx_data", tx_data, m_data);
    check_eq("fifo_level", fifo_level, mq.size());
    check_eq("overflow", overflow, m_ovf);
    check_eq("tx_en", tx_en, m_en);
`ifdef MMIO_UART_STATS_EN
    check_eq("tx_count", tx_count, m_cnt);
`endif
  endtask

  task automatic cycle(input logic r, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    rst      = r;
    mem_we   = we;
    mem_addr = a;
    mem_data = d;
    tx_ready = rdy;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(we, a, d, rdy);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    logic [7:0]  held;
    logic [31:0] a, d;
    rst = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_data = '0; tx_ready = 1'b0;

    // Reset values
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_tx_en", tx_en, 1'b1);

    // Two bytes back-to-back with ready held high
    cycle(1'b0, 1'b1, DA, 32'h41, 1'b1);
    check_eq("lat_not_yet", tx_valid, 1'b0);
    cycle(1'b0, 1'b1, DA, 32'h42, 1'b1);
    check_eq("first_byte", tx_data, 8'h41);
    idle(1, 1'b1);
    check_eq("second_byte", tx_data, 8'h42);
    idle(1, 1'b1);
    check_eq("drained", tx_valid, 1'b0);

    // Overflow with ready low, then clear it
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, DA, 32'(i), 1'b0);
    check_eq("ovf_set", overflow, 1'b1);
    check_eq("full_level", fifo_level, 4'd8);
    cycle(1'b0, 1'b1, CA, 32'h3, 1'b0);
    check_eq("ovf_clr", overflow, 1'b0);

    // Stall holds data, one ready pulse advances
    held = tx_data;
    idle(5, 1'b0);
    check_eq("stall_hold", tx_data, held);
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(12, 1'b1);

    // Disabled transmitter queues but does not send
    cycle(1'b0, 1'b1, CA, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, DA, 32'h55, 1'b1);
    idle(3, 1'b1);
    check_eq("dis_level", fifo_level, 4'd1);
    cycle(1'b0, 1'b1, CA, 32'h1, 1'b1);
    idle(1, 1'b0);
    check_eq("en_send", tx_data, 8'h55);
    idle(2, 1'b1);

    // Flush while a byte is in flight
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DA, 32'h60 + 32'(i), 1'b0);
    cycle(1'b0, 1'b1, CA, 32'h5, 1'b0);
    check_eq("flush_level", fifo_level, 4'd0);
    idle(2, 1'b0);
    idle(4, 1'b1);
    check_eq("flush_idle", tx_valid, 1'b0);

    // Counter clear and count
    cycle(1'b0, 1'b1, CA, 32'h9, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, DA, 32'h70 + 32'(i), 1'b1);
    idle(4, 1'b1);
`ifdef MMIO_UART_STATS_EN
    check_eq("cnt_three", tx_count, 16'd3);
    cycle(1'b0, 1'b1, CA, 32'h9, 1'b1);
    check_eq("cnt_clear", tx_count, 16'd0);
    check_eq("cnt_en", tx_en, 1'b1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 40)      a = DA;
      else if (sel < 52) a = CA;
      else if (sel < 60) a = 32'h0000_0102;
      else               a = $urandom;
      d = $urandom;
      if (a == CA) begin
        d[0] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
      end
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, a, d,
            $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
